pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the RISC-V core, successor to the fixed-field stage registers between decode/execute/memory/writeback. Carries a generic control vector and data payload with a valid/ready handshake, synchronous flush (bubble insertion), stall via back-pressure, and an optional two-entry skid buffer. It breaks the combinational ready path across stages. It is instantiated once per stage boundary, with field packing defined in the shared package.

## Interface
Parameters:
- CTRL_W, 8: width of the control vector (regWrite, memWrite, resultSRC, …); forced to zero on bubbles.
- DATA_W, 96: width of the data payload (ALU result, RD2, PC+4, …); never cleared except by reset.
- SKID, 0: 0 selects a single register with combinational in_ready_o; 1 selects a two-entry skid buffer with registered in_ready_o.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; discards all held entries and the current input.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  stage can accept; transfer when in_valid_i && in_ready_o.
- in_ctrl_i  in  CTRL_W  upstream control vector.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  entry presented downstream.
- out_ready_i  in  1  downstream accepts; transfer when out_valid_o && out_ready_i.
- out_ctrl_o  out  CTRL_W  control vector; 0 whenever out_valid_o=0.
- out_data_o  out  DATA_W  payload; holds its last value when invalid.
- occ_o  out  2  entries held (0..1 for SKID=0, 0..2 for SKID=1).

## Operation
- Reset (rst_n low, asynchronous): state EMPTY, out_valid_o=0, out_ctrl_o=0, out_data_o=0, occ_o=0, in_ready_o=1. Handshakes during reset are ignored.
- SKID=0: one entry. in_ready_o = !out_valid_o || out_ready_i. On an input transfer, the entry loads. On an output transfer with no input transfer, the entry empties.
- SKID=1: states EMPTY, ONE, TWO. Main register drives the outputs; skid register holds the overflow entry.
  - EMPTY: input transfer → ONE.
  - ONE: input-only → TWO (into skid); output-only → EMPTY; both → ONE (main reloads).
  - TWO: input is never accepted. Output transfer → ONE, with skid moved to main.
  - in_ready_o = (state != TWO), driven from the state register only. There is no combinational path from out_ready_i.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush has priority over all handshakes. On the next edge: state EMPTY, out_valid_o=0, out_ctrl_o=0, occ_o=0. The input presented in the flush cycle is discarded. out_data_o is not cleared.
- Invalid outputs: out_ctrl_o is gated to zero, so a bubble never writes registers or memory.

## Timing
- Latency: 1 cycle from input transfer to out_valid_o, with an empty stage and no stall.
- Throughput: 1 entry/cycle in both modes while out_ready_i=1.
- SKID=1 stall: out_ready_i drops in cycle N. The input transfer in cycle N still lands in skid (occ_o=2). in_ready_o=0 from cycle N+1.
- Simultaneous input and output transfer in ONE (or in SKID=0 full): occupancy is unchanged and the new entry appears next cycle.
- Flush together with an output transfer: the downstream transfer completes in that cycle, then the stage is empty.
- Reset asserted mid-stream: outputs reach reset values immediately, without waiting for a clock edge. After release, the first transfer is accepted on the first rising edge.

## Structure
- Shared package pipe_pkg contains:
  - enum pipe_state_e {EMPTY, ONE, TWO};
  - per-boundary packed structs (ex_mem_ctrl_t, ex_mem_data_t, …) and localparams giving their widths for CTRL_W/DATA_W.
- Sub-module pipe_skid_buf implements the SKID=1 datapath and FSM. It is instantiated in a generate branch; SKID=0 is inline logic.

## Test plan
- Reset: assert rst_n=0 mid-stream with occ_o=2 → outputs immediately 0, in_ready_o=1; after release, in_data_i=32'hA5 with in_valid_i=1 → out_valid_o=1 and out_data_o=32'hA5 the next cycle.
- Streaming: 16 back-to-back entries 0..15 with out_ready_i=1, both SKID values → outputs 0..15 in order, one per cycle, latency 1.
- Stall, SKID=1: send 1,2,3 while out_ready_i=0 from the second cycle → occ_o=2, in_ready_o=0, 3 not accepted; release → 1,2,3 delivered in order with no loss.
- Flush: occ_o=2 with in_ctrl_i=8'hFF, pulse flush_i → next cycle out_valid_o=0, out_ctrl_o=0, occ_o=0; the flushed-cycle input never appears at the output.
- Random valid/ready with occasional flush, 10k cycles, against a scoreboard → in-order match, out_ctrl_o=0 whenever invalid, no combinational out_ready_i→in_ready_o path for SKID=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// Holds the occupancy state encoding and the per-boundary field packing
// whose widths size CTRL_W/DATA_W at each pipe_stage_reg instance.
package pipe_pkg;

    // Occupancy states; the encoding equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    // Execute -> memory boundary.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic [3:0] rsvd;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rd2;
        logic [31:0] pc_plus4;
    } ex_mem_data_t;

    // Memory -> writeback boundary.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic [4:0] rsvd;
    } mem_wb_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
    } mem_wb_data_t;

    localparam int unsigned EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int unsigned EX_MEM_DATA_W = $bits(ex_mem_data_t);
    localparam int unsigned MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);
    localparam int unsigned MEM_WB_DATA_W = $bits(mem_wb_data_t);

    // Number of entries held in a given state.
    function automatic logic [1:0] state_occ(input pipe_state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: main register drives the outputs, skid register
// absorbs the entry accepted in the cycle downstream stalls. in_ready_o is
// decoded from the state register alone, so out_ready_i never reaches it
// combinationally.
// Ports: clk, rst_n, flush_i; upstream in_valid_i/in_ready_o/in_ctrl_i/
// in_data_i; downstream out_valid_o/out_ready_i/out_ctrl_o/out_data_o;
// occ_o entries held (0..2).
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
);

    pipe_state_e       state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid_i && (state_q != TWO);
    assign out_fire = (state_q != EMPTY) && out_ready_i;

    // Next state; ctrl registers are zeroed whenever their entry leaves so
    // the ctrl output is already a bubble when invalid.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = ONE;
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end else if (in_fire) begin
                        state_d     = TWO;
                        skid_ctrl_d = in_ctrl_i;
                        skid_data_d = in_data_i;
                    end else if (out_fire) begin
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
    end

    // State and entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready_o  = (state_q != TWO);
    assign out_valid_o = (state_q != EMPTY);
    assign out_ctrl_o  = main_ctrl_q;
    assign out_data_o  = main_data_q;
    assign occ_o       = state_occ(state_q);

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// synchronous flush and optional two-entry skid buffer.
// Ports: clk, rst_n (async active-low), flush_i; upstream in_valid_i,
// in_ready_o, in_ctrl_i, in_data_i; downstream out_valid_o, out_ready_i,
// out_ctrl_o (zero when invalid), out_data_o (holds when invalid);
// occ_o entries held.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = EX_MEM_CTRL_W,
    parameter int unsigned DATA_W = EX_MEM_DATA_W,
    parameter int unsigned SKID   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
);

    if (SKID == 0) begin : g_single
        // Single entry; ready passes through combinationally from downstream.
        logic              valid_q, valid_d;
        logic [CTRL_W-1:0] ctrl_q, ctrl_d;
        logic [DATA_W-1:0] data_q, data_d;
        logic              in_fire;
        logic              out_fire;

        assign in_ready_o = !valid_q || out_ready_i;
        assign in_fire    = in_valid_i && in_ready_o;
        assign out_fire   = valid_q && out_ready_i;

        // Flush wins over load; data is kept so only ctrl marks the bubble.
        always_comb begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
            data_d  = data_q;
            if (flush_i) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end else if (in_fire) begin
                valid_d = 1'b1;
                ctrl_d  = in_ctrl_i;
                data_d  = in_data_i;
            end else if (out_fire) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                ctrl_q  <= ctrl_d;
                data_q  <= data_d;
            end
        end

        assign out_valid_o = valid_q;
        assign out_ctrl_o  = ctrl_q;
        assign out_data_o  = data_q;
        assign occ_o       = {1'b0, valid_q};
    end else begin : g_skid
        pipe_skid_buf #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_skid (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush_i     (flush_i),
            .in_valid_i  (in_valid_i),
            .in_ready_o  (in_ready_o),
            .in_ctrl_i   (in_ctrl_i),
            .in_data_i   (in_data_i),
            .out_valid_o (out_valid_o),
            .out_ready_i (out_ready_i),
            .out_ctrl_o  (out_ctrl_o),
            .out_data_o  (out_data_o),
            .occ_o       (occ_o)
        );
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: drives one SKID=0 and one SKID=1 instance with
// shared stimulus; each has its own scoreboard queue.
module tb_pipe_stage_reg;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 96;
    localparam int unsigned IW = CW + DW;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready  [2];
    logic          out_valid [2];
    logic [CW-1:0] out_ctrl  [2];
    logic [DW-1:0] out_data  [2];
    logic [1:0]    occ       [2];

    logic [IW-1:0] sb [2][$];

    int tests_run;
    int tests_failed;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
        .out_ctrl_o(out_ctrl[0]), .out_data_o(out_data[0]), .occ_o(occ[0])
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
        .out_ctrl_o(out_ctrl[1]), .out_data_o(out_data[1]), .occ_o(occ[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard at the falling edge: check presented state against the
    // model, then retire the output transfer and record the input transfer.
    task automatic monitor();
        logic exp_rdy;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                sb[k].delete();
                continue;
            end
            exp_rdy = (k == 0) ? (sb[k].size() == 0 || out_ready) : (sb[k].size() != 2);
            tests_run++;
            if (in_ready[k] !== exp_rdy) begin
                tests_failed++;
                $display("FAIL sb_in_ready dut%0d: got %b expected %b", k, in_ready[k], exp_rdy);
            end
            tests_run++;
            if (occ[k] !== 2'(sb[k].size())) begin
                tests_failed++;
                $display("FAIL sb_occ dut%0d: got %0d expected %0d", k, occ[k], sb[k].size());
            end
            tests_run++;
            if (out_valid[k] !== (sb[k].size() != 0)) begin
                tests_failed++;
                $display("FAIL sb_valid dut%0d: got %b expected %b", k, out_valid[k], sb[k].size() != 0);
            end
            if (out_valid[k] !== 1'b1) begin
                tests_run++;
                if (out_ctrl[k] !== '0) begin
                    tests_failed++;
                    $display("FAIL sb_bubble_ctrl dut%0d: got %h expected 00", k, out_ctrl[k]);
                end
            end else if (sb[k].size() != 0) begin
                tests_run++;
                if ({out_ctrl[k], out_data[k]} !== sb[k][0]) begin
                    tests_failed++;
                    $display("FAIL sb_entry dut%0d: got %h expected %h", k, {out_ctrl[k], out_data[k]}, sb[k][0]);
                end
            end
            if (out_valid[k] === 1'b1 && out_ready && sb[k].size() != 0)
                void'(sb[k].pop_front());
            if (flush)
                sb[k].delete();
            else if (in_valid && in_ready[k] === 1'b1)
                sb[k].push_back({in_ctrl, in_data});
        end
    endtask

    // One cycle: scoreboard on the falling edge, return #1 after rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (out_valid[k] !== 1'b0 || out_ctrl[k] !== '0 || out_data[k] !== '0 ||
                occ[k] !== 2'd0 || in_ready[k] !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s dut%0d: got v=%b c=%h d=%h occ=%0d rdy=%b expected v=0 c=0 d=0 occ=0 rdy=1",
                         tag, k, out_valid[k], out_ctrl[k], out_data[k], occ[k], in_ready[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        check_reset_values("reset_hold");
        rst_n    = 1'b1;
        in_valid = 1'b1; in_ctrl = 8'h11; in_data = DW'(1);
        step();
        in_data  = DW'(2);
        step();
        in_valid = 1'b0;
        tests_run++;
        if (occ[1] !== 2'd2) begin
            tests_failed++;
            $display("FAIL reset_prefill_occ dut1: got %0d expected 2", occ[1]);
        end
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("reset_async");
        step();
        rst_n = 1'b1; in_valid = 1'b1; in_ctrl = 8'h3C; in_data = DW'(32'hA5);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (out_valid[k] !== 1'b1 || out_data[k] !== DW'(32'hA5)) begin
                tests_failed++;
                $display("FAIL reset_first_xfer dut%0d: got v=%b d=%h expected v=1 d=a5", k, out_valid[k], out_data[k]);
            end
        end
        out_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_ctrl = CW'(i + 1); in_data = DW'(i);
            step();
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (out_valid[k] !== 1'b1 || out_data[k] !== DW'(i) || out_ctrl[k] !== CW'(i + 1)) begin
                    tests_failed++;
                    $display("FAIL stream_%0d dut%0d: got v=%b c=%h d=%h expected v=1 c=%h d=%h",
                             i, k, out_valid[k], out_ctrl[k], out_data[k], CW'(i + 1), DW'(i));
                end
            end
        end
        in_valid = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (out_valid[k] !== 1'b0) begin
                tests_failed++;
                $display("FAIL stream_drain dut%0d: got v=%b expected 0", k, out_valid[k]);
            end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h01; in_data = DW'(1);
        step();
        out_ready = 1'b0; in_ctrl = 8'h02; in_data = DW'(2);
        step();
        in_ctrl = 8'h03; in_data = DW'(3);
        // Raise out_ready mid-cycle: only the SKID=0 ready may follow it.
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_no_comb_path dut1: got rdy=%b expected 0", in_ready[1]);
        end
        tests_run++;
        if (in_ready[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_comb_path dut0: got rdy=%b expected 1", in_ready[0]);
        end
        out_ready = 1'b0;
        #1;
        step();
        tests_run++;
        if (occ[1] !== 2'd2 || in_ready[1] !== 1'b0 || out_data[1] !== DW'(1)) begin
            tests_failed++;
            $display("FAIL stall_held dut1: got occ=%0d rdy=%b d=%h expected occ=2 rdy=0 d=1",
                     occ[1], in_ready[1], out_data[1]);
        end
        out_ready = 1'b1;
        step();
        tests_run++;
        if (occ[1] !== 2'd1 || out_data[1] !== DW'(2)) begin
            tests_failed++;
            $display("FAIL stall_release1 dut1: got occ=%0d d=%h expected occ=1 d=2", occ[1], out_data[1]);
        end
        step();
        tests_run++;
        if (occ[1] !== 2'd1 || out_data[1] !== DW'(3)) begin
            tests_failed++;
            $display("FAIL stall_release2 dut1: got occ=%0d d=%h expected occ=1 d=3", occ[1], out_data[1]);
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if (out_valid[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_empty dut1: got v=%b expected 0", out_valid[1]);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = DW'(32'h10);
        step();
        in_data = DW'(32'h11);
        step();
        tests_run++;
        if (occ[1] !== 2'd2) begin
            tests_failed++;
            $display("FAIL flush_prefill dut1: got occ=%0d expected 2", occ[1]);
        end
        // Flush alongside a downstream transfer and a fresh input.
        flush = 1'b1; out_ready = 1'b1; in_data = DW'(32'h99);
        step();
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (out_valid[k] !== 1'b0 || out_ctrl[k] !== '0 || occ[k] !== 2'd0 || out_data[k] !== DW'(32'h10)) begin
                tests_failed++;
                $display("FAIL flush_result dut%0d: got v=%b c=%h occ=%0d d=%h expected v=0 c=0 occ=0 d=10",
                         k, out_valid[k], out_ctrl[k], occ[k], out_data[k]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (out_valid[k] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL flush_no_ghost dut%0d: got v=%b d=%h expected v=0", k, out_valid[k], out_data[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_ctrl   = CW'($urandom);
            in_data   = {$urandom, $urandom, $urandom};
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (sb[k].size() != 0) begin
                tests_failed++;
                $display("FAIL random_drained dut%0d: got %0d pending expected 0", k, sb[k].size());
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
